dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DM_ADDRESS, default 9, byte-address width of the data memory.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter WAIT_CYCLES, default 2, wait states inserted between request acceptance and response; legal range 0..15.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  pipeline presents a memory request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  DM_ADDRESS  byte address.
REQ-009 req_wdata  input  DATA_W  store data; the operand is in the low bits.
REQ-010 req_funct3  input  3  RV32I width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-011 req_ready  output  1  responder can accept a request this cycle.
REQ-012 rsp_valid  output  1  one-cycle response strobe.
REQ-013 rsp_rdata  output  DATA_W  extended load data; 0 for stores and errors.
REQ-014 rsp_err  output  1  request was misaligned or used an illegal funct3.

Function
REQ-015 Storage shall be 2^(DM_ADDRESS-2) words of DATA_W bits, little-endian, indexed by req_addr[DM_ADDRESS-1:2].
REQ-016 The FSM shall have three states: IDLE, WAIT and RESP.
REQ-017 req_ready shall be 1 in IDLE and 0 in WAIT and RESP.
REQ-018 A request is accepted on a rising edge where req_valid=1 and req_ready=1. At acceptance, we, addr, wdata and funct3 are latched. Request inputs are ignored at all other times.
REQ-019 On acceptance with WAIT_CYCLES>0, the FSM shall go IDLE->WAIT and load a 4-bit counter with WAIT_CYCLES-1.
REQ-020 On acceptance with WAIT_CYCLES=0, the FSM shall go IDLE->RESP directly.
REQ-021 In WAIT, the counter decrements each cycle. The FSM goes WAIT->RESP on the edge where the counter equals 0.
REQ-022 Latency: for acceptance at edge N, rsp_valid shall be 1 during exactly cycle N+WAIT_CYCLES+1 and 0 otherwise.
REQ-023 RESP lasts exactly one cycle and then returns to IDLE, so back-to-back requests are accepted every WAIT_CYCLES+2 cycles.
REQ-024 Error cases:
  - funct3 of 011, 110 or 111 shall set rsp_err=1.
  - Halfword access with addr[0]=1 shall set rsp_err=1.
  - Word access with addr[1:0]!=00 shall set rsp_err=1.
  - On error, no memory write occurs and rsp_rdata=0.
REQ-025 A legal store shall update only the addressed byte lanes (SB: 1 lane at addr[1:0]; SH: 2 lanes at addr[1]; SW: 4 lanes). The write is committed on the edge ending the RESP cycle.
REQ-026 A legal load shall read from the latched address during RESP and drive rsp_rdata:
  - LB and LH are sign-extended.
  - LBU and LHU are zero-extended.
  - LW is returned unchanged.
REQ-027 rsp_rdata and rsp_err shall be 0 whenever rsp_valid=0.
REQ-028 A load issued after a store completes shall observe the stored data. No read-during-write hazard exists, because only one request is outstanding at a time.

Reset
REQ-029 reset=1 at an edge shall:
  - put the FSM in IDLE and clear the counter and latched request;
  - clear all memory words to 0;
  - drive req_ready=1 and rsp_valid=0, rsp_rdata=0, rsp_err=0 from the next cycle.
REQ-030 Reset asserted in WAIT or RESP shall abort the pending request: no write is performed and no response is issued.
REQ-031 reset shall have priority over a simultaneous req_valid; that request is not accepted.

Verification
REQ-032 After reset with WAIT_CYCLES=2:
  - SW addr=0x010 wdata=0xDEADBEEF accepted at edge N gives rsp_valid in cycle N+3 with rsp_err=0.
  - A following LW 0x010 returns 0xDEADBEEF.
REQ-033 After mem[0x010]=0xDEADBEEF:
  - SB addr=0x011 wdata=0x000000A5, then LW 0x010, returns 0xDEADA5EF.
  - LB 0x011 returns 0xFFFFFFA5.
  - LBU 0x011 returns 0x000000A5.
REQ-034 Alignment and funct3 errors:
  - SH addr=0x013 sets rsp_err=1; a subsequent LW 0x010 is unchanged.
  - LW addr=0x012 sets rsp_err=1 with rsp_rdata=0.
  - funct3=011 sets rsp_err=1.
REQ-035 With WAIT_CYCLES=0, req_valid held high continuously is accepted every 2nd cycle, and req_ready toggles 1,0,1,0.
REQ-036 Reset mid-operation:
  - Assert reset in the WAIT cycle of SW 0x020=0x12345678; rsp_valid is never raised.
  - A later LW 0x020 returns 0x00000000.
REQ-037 Request inputs changing while req_ready=0 shall not affect the in-flight response.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response bus between the pipeline (master) and the data memory (slave).
interface dmem_responder_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  req_valid;
    logic                  req_we;
    logic [DM_ADDRESS-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [2:0]            req_funct3;
    logic                  req_ready;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data memory with a fixed number of wait states; one request in flight at a time.
// Loads/stores follow RV32I width codes; misaligned or illegal requests report rsp_err.
module dmem_responder #(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);
    localparam int WORDS = 1 << (DM_ADDRESS - 2);
    localparam int LANES = DATA_W / 8;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state, state_nxt;
    logic [3:0]            cnt;
    logic                  l_we;
    logic [DM_ADDRESS-1:0] l_addr;
    logic [DATA_W-1:0]     l_wdata;
    logic [2:0]            l_f3;
    logic [DATA_W-1:0]     mem [WORDS];

    logic                  accept;
    logic                  err;
    logic [DATA_W-1:0]     word;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;
    logic [DATA_W-1:0]     load_data;
    logic [LANES-1:0]      wmask;
    logic [LANES-1:0][7:0] wbytes;

    assign accept = (state == IDLE) && bus.req_valid;

    // Illegal width codes, then alignment against the access size.
    assign err = (l_f3 == 3'b011) || (l_f3 == 3'b110) || (l_f3 == 3'b111) ||
                 ((l_f3[1:0] == 2'b01) && l_addr[0]) ||
                 ((l_f3[1:0] == 2'b10) && (l_addr[1:0] != 2'b00));

    assign word   = mem[l_addr[DM_ADDRESS-1:2]];
    assign byte_v = word[{l_addr[1:0], 3'b000} +: 8];
    assign half_v = word[{l_addr[1], 4'b0000} +: 16];

    // Select and extend the load operand by width code.
    always_comb begin
        load_data = '0;
        case (l_f3)
            3'b000:  load_data = {{(DATA_W-8){byte_v[7]}}, byte_v};
            3'b001:  load_data = {{(DATA_W-16){half_v[15]}}, half_v};
            3'b010:  load_data = word;
            3'b100:  load_data = {{(DATA_W-8){1'b0}}, byte_v};
            3'b101:  load_data = {{(DATA_W-16){1'b0}}, half_v};
            default: load_data = '0;
        endcase
    end

    // Byte-lane enables and lane data for stores; operand comes from the low bits.
    always_comb begin
        wmask  = '0;
        wbytes = '0;
        for (int i = 0; i < LANES; i++) begin
            case (l_f3[1:0])
                2'b00: begin
                    wmask[i]  = (i[1:0] == l_addr[1:0]);
                    wbytes[i] = l_wdata[7:0];
                end
                2'b01: begin
                    wmask[i]  = (i[1] == l_addr[1]);
                    wbytes[i] = l_wdata[8*(i%2) +: 8];
                end
                2'b10: begin
                    wmask[i]  = 1'b1;
                    wbytes[i] = l_wdata[8*i +: 8];
                end
                default: begin
                    wmask[i]  = 1'b0;
                    wbytes[i] = 8'h00;
                end
            endcase
        end
    end

    // State, wait counter and latched request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            l_we    <= 1'b0;
            l_addr  <= '0;
            l_wdata <= '0;
            l_f3    <= 3'b000;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt     <= WAIT_INIT;
                l_we    <= bus.req_we;
                l_addr  <= bus.req_addr;
                l_wdata <= bus.req_wdata;
                l_f3    <= bus.req_funct3;
            end else if ((state == WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Storage: cleared on reset, legal stores commit at the end of RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < WORDS; w++) mem[w] <= '0;
        end else if ((state == RESP) && l_we && !err) begin
            for (int i = 0; i < LANES; i++)
                if (wmask[i]) mem[l_addr[DM_ADDRESS-1:2]][8*i +: 8] <= wbytes[i];
        end
    end

    // Next state and bus outputs; response fields are zero outside RESP.
    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = 1'b0;
        bus.rsp_rdata = '0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
            WAIT: begin
                if (cnt == 4'd0) state_nxt = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = err;
                bus.rsp_rdata = (err || l_we) ? '0 : load_data;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: table of load/store vectors on a 2-wait-state responder,
// plus reset-abort, reset-priority and zero-wait back-to-back sequences.
module tb_dmem_responder;
    localparam int W0 = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dmem_responder_if #(.DM_ADDRESS(9), .DATA_W(32)) bus0 ();
    dmem_responder_if #(.DM_ADDRESS(9), .DATA_W(32)) bus1 ();

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(W0)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    typedef struct {
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One request on the 2-wait DUT; inputs are scrambled while it is busy.
    task automatic run_req(input string tag, input vec_t v);
        @(negedge clk);
        chk({tag, ".ready"}, 32'(bus0.req_ready), 32'd1);
        chk({tag, ".idle_valid"}, 32'(bus0.rsp_valid), 32'd0);
        bus0.req_valid  = 1'b1;
        bus0.req_we     = v.we;
        bus0.req_addr   = v.addr;
        bus0.req_wdata  = v.wdata;
        bus0.req_funct3 = v.f3;
        @(posedge clk);
        for (int k = 1; k <= W0 + 1; k++) begin
            @(negedge clk);
            if (k < W0 + 1) begin
                chk($sformatf("%s.early_valid%0d", tag, k), 32'(bus0.rsp_valid), 32'd0);
                bus0.req_we     = ~v.we;
                bus0.req_addr   = 9'($urandom);
                bus0.req_wdata  = $urandom;
                bus0.req_funct3 = 3'($urandom);
            end else begin
                chk({tag, ".rsp_valid"}, 32'(bus0.rsp_valid), 32'd1);
                chk({tag, ".rdata"}, bus0.rsp_rdata, v.exp_rdata);
                chk({tag, ".err"}, 32'(bus0.rsp_err), 32'(v.exp_err));
                bus0.req_valid = 1'b0;
            end
        end
    endtask

    // One request on the zero-wait DUT.
    task automatic run_req1(input string tag, input vec_t v);
        @(negedge clk);
        chk({tag, ".ready"}, 32'(bus1.req_ready), 32'd1);
        bus1.req_valid  = 1'b1;
        bus1.req_we     = v.we;
        bus1.req_addr   = v.addr;
        bus1.req_wdata  = v.wdata;
        bus1.req_funct3 = v.f3;
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".rsp_valid"}, 32'(bus1.rsp_valid), 32'd1);
        chk({tag, ".rdata"}, bus1.rsp_rdata, v.exp_rdata);
        chk({tag, ".err"}, 32'(bus1.rsp_err), 32'(v.exp_err));
        bus1.req_valid = 1'b0;
    endtask

    initial begin
        //            we    addr    wdata         f3      exp_rdata     err
        tbl.push_back('{1'b1, 9'h010, 32'hDEADBEEF, 3'b010, 32'h00000000, 1'b0});
        tbl.push_back('{1'b0, 9'h010, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0});
        tbl.push_back('{1'b1, 9'h011, 32'h000000A5, 3'b000, 32'h00000000, 1'b0});
        tbl.push_back('{1'b0, 9'h010, 32'h0,        3'b010, 32'hDEADA5EF, 1'b0});
        tbl.push_back('{1'b0, 9'h011, 32'h0,        3'b000, 32'hFFFFFFA5, 1'b0});
        tbl.push_back('{1'b0, 9'h011, 32'h0,        3'b100, 32'h000000A5, 1'b0});
        tbl.push_back('{1'b1, 9'h013, 32'h0000FFFF, 3'b001, 32'h00000000, 1'b1});
        tbl.push_back('{1'b0, 9'h010, 32'h0,        3'b010, 32'hDEADA5EF, 1'b0});
        tbl.push_back('{1'b0, 9'h012, 32'h0,        3'b010, 32'h00000000, 1'b1});
        tbl.push_back('{1'b0, 9'h010, 32'h0,        3'b011, 32'h00000000, 1'b1});
        tbl.push_back('{1'b0, 9'h010, 32'h0,        3'b110, 32'h00000000, 1'b1});
        tbl.push_back('{1'b1, 9'h010, 32'hFFFFFFFF, 3'b111, 32'h00000000, 1'b1});
        tbl.push_back('{1'b1, 9'h011, 32'hFFFFFFFF, 3'b010, 32'h00000000, 1'b1});
        tbl.push_back('{1'b0, 9'h010, 32'h0,        3'b010, 32'hDEADA5EF, 1'b0});
        tbl.push_back('{1'b0, 9'h012, 32'h0,        3'b001, 32'hFFFFDEAD, 1'b0});
        tbl.push_back('{1'b0, 9'h012, 32'h0,        3'b101, 32'h0000DEAD, 1'b0});
        tbl.push_back('{1'b0, 9'h011, 32'h0,        3'b001, 32'h00000000, 1'b1});
        tbl.push_back('{1'b1, 9'h012, 32'hABCD1234, 3'b001, 32'h00000000, 1'b0});
        tbl.push_back('{1'b0, 9'h010, 32'h0,        3'b010, 32'h1234A5EF, 1'b0});
        tbl.push_back('{1'b0, 9'h010, 32'h0,        3'b001, 32'hFFFFA5EF, 1'b0});
        tbl.push_back('{1'b0, 9'h013, 32'h0,        3'b000, 32'h00000012, 1'b0});
        tbl.push_back('{1'b0, 9'h010, 32'h0,        3'b000, 32'hFFFFFFEF, 1'b0});
        tbl.push_back('{1'b1, 9'h012, 32'hFFFFFF3C, 3'b000, 32'h00000000, 1'b0});
        tbl.push_back('{1'b0, 9'h010, 32'h0,        3'b010, 32'h123CA5EF, 1'b0});
        tbl.push_back('{1'b1, 9'h1FC, 32'h80000001, 3'b010, 32'h00000000, 1'b0});
        tbl.push_back('{1'b0, 9'h1FC, 32'h0,        3'b010, 32'h80000001, 1'b0});
        tbl.push_back('{1'b0, 9'h1FF, 32'h0,        3'b000, 32'hFFFFFF80, 1'b0});
        tbl.push_back('{1'b0, 9'h1FC, 32'h0,        3'b100, 32'h00000001, 1'b0});
        tbl.push_back('{1'b1, 9'h030, 32'hCAFEF00D, 3'b010, 32'h00000000, 1'b0});
        tbl.push_back('{1'b0, 9'h030, 32'h0,        3'b010, 32'hCAFEF00D, 1'b0});

        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0;
        bus0.req_wdata = '0;   bus0.req_funct3 = 3'b000;
        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0;
        bus1.req_wdata = '0;   bus1.req_funct3 = 3'b000;

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.ready", 32'(bus0.req_ready), 32'd1);
        chk("rst.valid", 32'(bus0.rsp_valid), 32'd0);
        chk("rst.rdata", bus0.rsp_rdata, 32'd0);
        chk("rst.err",   32'(bus0.rsp_err), 32'd0);
        reset = 1'b0;

        foreach (tbl[i]) run_req($sformatf("vec%0d", i), tbl[i]);

        // Reset during WAIT aborts the store and suppresses the response
        @(negedge clk);
        bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_addr = 9'h020;
        bus0.req_wdata = 32'h12345678; bus0.req_funct3 = 3'b010;
        @(posedge clk);
        @(negedge clk);
        chk("abort.in_wait", 32'(bus0.req_ready), 32'd0);
        reset = 1'b1;
        bus0.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("abort.ready", 32'(bus0.req_ready), 32'd1);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("abort.no_rsp%0d", k), 32'(bus0.rsp_valid), 32'd0);
            @(negedge clk);
        end
        run_req("abort.lw020", '{1'b0, 9'h020, 32'h0, 3'b010, 32'h00000000, 1'b0});
        run_req("abort.lw030", '{1'b0, 9'h030, 32'h0, 3'b010, 32'h00000000, 1'b0});

        // Reset wins over a simultaneous request
        @(negedge clk);
        reset = 1'b1;
        bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_addr = 9'h040;
        bus0.req_wdata = 32'h11111111; bus0.req_funct3 = 3'b010;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus0.req_valid = 1'b0;
        chk("prio.ready", 32'(bus0.req_ready), 32'd1);
        for (int k = 0; k < W0 + 2; k++) begin
            @(negedge clk);
            chk($sformatf("prio.no_rsp%0d", k), 32'(bus0.rsp_valid), 32'd0);
        end
        run_req("prio.lw040", '{1'b0, 9'h040, 32'h0, 3'b010, 32'h00000000, 1'b0});

        // Zero wait states: continuous req_valid accepted every other cycle
        @(negedge clk);
        bus1.req_valid = 1'b1; bus1.req_we = 1'b0; bus1.req_addr = 9'h000;
        bus1.req_funct3 = 3'b010;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("w0.ready%0d", k), 32'(bus1.req_ready), 32'(k % 2 == 0));
            chk($sformatf("w0.valid%0d", k), 32'(bus1.rsp_valid), 32'(k % 2 == 1));
            @(negedge clk);
        end
        bus1.req_valid = 1'b0;
        @(negedge clk);
        run_req1("w0.sw008", '{1'b1, 9'h008, 32'h80017FFF, 3'b010, 32'h00000000, 1'b0});
        run_req1("w0.lh008", '{1'b0, 9'h008, 32'h0,        3'b001, 32'h00007FFF, 1'b0});
        run_req1("w0.lh00a", '{1'b0, 9'h00A, 32'h0,        3'b001, 32'hFFFF8001, 1'b0});
        run_req1("w0.lw00b", '{1'b0, 9'h00B, 32'h0,        3'b010, 32'h00000000, 1'b1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
